isp_awb: RTL and testbench



---
 rtl/isp_awb.sv | 198 +++++++++++++++++++
 tb/tb_isp_awb.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/isp_awb.sv
// Gray-world auto white balance: per-frame R/G/B statistics, serial gain divider,
// and a 3-stage gain/clip pipeline feeding the colour correction matrix.
module isp_awb #(
    parameter int BITS   = 8,
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 960,
    parameter int SUM_W  = 32
) (
    input  logic                pclk,
    input  logic                rst_n,
    input  logic                in_awb_enable,
    input  logic                in_rgb_data_en,
    input  logic [3*BITS-1:0]   in_rgb_data,
    output logic                out_awb_rgb_en,
    output logic [3*BITS-1:0]   out_awb_rgb,
    output logic [9:0]          out_gain_r,
    output logic [9:0]          out_gain_b,
    output logic                out_gain_valid
);

    localparam int NPIX   = WIDTH * HEIGHT;
    localparam int CNT_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int PROD_W = BITS + 10;
    localparam int DIV_W  = SUM_W + 10;
    localparam logic [9:0]       GAIN_UNITY = 10'd256;
    localparam logic [9:0]       GAIN_MAX   = 10'd1023;
    localparam logic [BITS-1:0]  PIX_MAX    = {BITS{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE, ST_CHK_R, ST_DIV_R, ST_CHK_B, ST_DIV_B, ST_UPDATE
    } state_t;

    // Drop the 8 fractional bits of a Q2.8 product and saturate to the pixel range.
    function automatic logic [BITS-1:0] clip_q8(input logic [PROD_W-1:0] prod);
        logic [PROD_W-1:0] sh;
        sh = prod >> 8;
        if (sh > {{(PROD_W-BITS){1'b0}}, PIX_MAX}) begin
            return PIX_MAX;
        end else begin
            return sh[BITS-1:0];
        end
    endfunction

    state_t             state_r, state_nxt_s;
    logic [CNT_W-1:0]   pix_cnt_r;
    logic [SUM_W-1:0]   sum_r_r, sum_g_r, sum_b_r;
    logic [SUM_W-1:0]   snap_r_r, snap_g_r, snap_b_r;
    logic [DIV_W-1:0]   div_rem_r, div_den_r;
    logic [3:0]         div_cnt_r;
    logic [9:0]         gain_r_new_r, gain_b_new_r;
    logic [BITS-1:0]    pix_r_s, pix_g_s, pix_b_s;
    logic               frame_done_s, skip_r_s, skip_b_s, div_ge_s, div_last_s;
    logic [9:0]         gain_r_eff_s, gain_b_eff_s;

    logic [3*BITS-1:0]  pix_s1_r;
    logic [9:0]         gain_r_s1_r, gain_b_s1_r;
    logic               en_s1_r, en_s2_r;
    logic [PROD_W-1:0]  prod_r_s2_r, prod_b_s2_r;
    logic [BITS-1:0]    g_s2_r;

    assign pix_r_s      = in_rgb_data[3*BITS-1:2*BITS];
    assign pix_g_s      = in_rgb_data[2*BITS-1:BITS];
    assign pix_b_s      = in_rgb_data[BITS-1:0];
    assign frame_done_s = in_rgb_data_en && (pix_cnt_r == CNT_W'(NPIX - 1));
    // Gains above 4.0 are not representable in Q2.8, so those cases saturate without dividing.
    assign skip_r_s     = (snap_r_r == '0) || ({2'b00, snap_g_r} >= {snap_r_r, 2'b00});
    assign skip_b_s     = (snap_b_r == '0) || ({2'b00, snap_g_r} >= {snap_b_r, 2'b00});
    assign div_ge_s     = (div_rem_r >= div_den_r);
    assign div_last_s   = (div_cnt_r == 4'd9);
    assign gain_r_eff_s = in_awb_enable ? out_gain_r : GAIN_UNITY;
    assign gain_b_eff_s = in_awb_enable ? out_gain_b : GAIN_UNITY;

    // Frame statistics; the closing pixel goes into the snapshot, not the next frame.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt_r <= '0;
            sum_r_r   <= '0;
            sum_g_r   <= '0;
            sum_b_r   <= '0;
            snap_r_r  <= '0;
            snap_g_r  <= '0;
            snap_b_r  <= '0;
        end else if (frame_done_s) begin
            pix_cnt_r <= '0;
            sum_r_r   <= '0;
            sum_g_r   <= '0;
            sum_b_r   <= '0;
            if (state_r == ST_IDLE) begin
                snap_r_r <= sum_r_r + {{(SUM_W-BITS){1'b0}}, pix_r_s};
                snap_g_r <= sum_g_r + {{(SUM_W-BITS){1'b0}}, pix_g_s};
                snap_b_r <= sum_b_r + {{(SUM_W-BITS){1'b0}}, pix_b_s};
            end
        end else if (in_rgb_data_en) begin
            pix_cnt_r <= pix_cnt_r + CNT_W'(1);
            sum_r_r   <= sum_r_r + {{(SUM_W-BITS){1'b0}}, pix_r_s};
            sum_g_r   <= sum_g_r + {{(SUM_W-BITS){1'b0}}, pix_g_s};
            sum_b_r   <= sum_b_r + {{(SUM_W-BITS){1'b0}}, pix_b_s};
        end
    end

    // Gain FSM state register.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Gain FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:   state_nxt_s = frame_done_s ? ST_CHK_R : ST_IDLE;
            ST_CHK_R:  state_nxt_s = skip_r_s ? ST_CHK_B : ST_DIV_R;
            ST_DIV_R:  state_nxt_s = div_last_s ? ST_CHK_B : ST_DIV_R;
            ST_CHK_B:  state_nxt_s = skip_b_s ? ST_UPDATE : ST_DIV_B;
            ST_DIV_B:  state_nxt_s = div_last_s ? ST_UPDATE : ST_DIV_B;
            ST_UPDATE: state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Restoring divider: divisor pre-shifted by 9 and walked down one bit per cycle,
    // quotient bits shifted straight into the pending gain register.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            div_rem_r      <= '0;
            div_den_r      <= '0;
            div_cnt_r      <= 4'd0;
            gain_r_new_r   <= GAIN_UNITY;
            gain_b_new_r   <= GAIN_UNITY;
            out_gain_r     <= GAIN_UNITY;
            out_gain_b     <= GAIN_UNITY;
            out_gain_valid <= 1'b0;
        end else begin
            out_gain_valid <= (state_r == ST_UPDATE);
            case (state_r)
                ST_CHK_R, ST_CHK_B: begin
                    div_rem_r <= {10'd0, snap_g_r} << 8;
                    div_cnt_r <= 4'd0;
                    if (state_r == ST_CHK_R) begin
                        div_den_r <= {10'd0, snap_r_r} << 9;
                        if (skip_r_s) gain_r_new_r <= GAIN_MAX;
                    end else begin
                        div_den_r <= {10'd0, snap_b_r} << 9;
                        if (skip_b_s) gain_b_new_r <= GAIN_MAX;
                    end
                end
                ST_DIV_R, ST_DIV_B: begin
                    if (div_ge_s) div_rem_r <= div_rem_r - div_den_r;
                    div_den_r <= div_den_r >> 1;
                    div_cnt_r <= div_cnt_r + 4'd1;
                    if (state_r == ST_DIV_R) begin
                        gain_r_new_r <= {gain_r_new_r[8:0], div_ge_s};
                    end else begin
                        gain_b_new_r <= {gain_b_new_r[8:0], div_ge_s};
                    end
                end
                ST_UPDATE: begin
                    out_gain_r <= gain_r_new_r;
                    out_gain_b <= gain_b_new_r;
                end
                default: begin
                    div_cnt_r <= 4'd0;
                end
            endcase
        end
    end

    // Three-stage apply pipeline: capture, multiply, shift/saturate.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            pix_s1_r       <= '0;
            gain_r_s1_r    <= 10'd0;
            gain_b_s1_r    <= 10'd0;
            en_s1_r        <= 1'b0;
            prod_r_s2_r    <= '0;
            prod_b_s2_r    <= '0;
            g_s2_r         <= '0;
            en_s2_r        <= 1'b0;
            out_awb_rgb    <= '0;
            out_awb_rgb_en <= 1'b0;
        end else begin
            pix_s1_r       <= in_rgb_data;
            gain_r_s1_r    <= gain_r_eff_s;
            gain_b_s1_r    <= gain_b_eff_s;
            en_s1_r        <= in_rgb_data_en;
            prod_r_s2_r    <= PROD_W'(pix_s1_r[3*BITS-1:2*BITS]) * PROD_W'(gain_r_s1_r);
            prod_b_s2_r    <= PROD_W'(pix_s1_r[BITS-1:0]) * PROD_W'(gain_b_s1_r);
            g_s2_r         <= pix_s1_r[2*BITS-1:BITS];
            en_s2_r        <= en_s1_r;
            out_awb_rgb_en <= en_s2_r;
            out_awb_rgb    <= en_s2_r ? {clip_q8(prod_r_s2_r), g_s2_r, clip_q8(prod_b_s2_r)} : '0;
        end
    end

endmodule

// File: tb/tb_isp_awb.sv
// Directed bench for isp_awb: small-frame instance for gain/clip/bypass checks,
// a 32-pixel instance for back-to-back frames with zero blanking.
module tb_isp_awb;

    logic        pclk;
    logic        rst_n;
    logic        awb_enable;
    logic        rgb_en;
    logic [23:0] rgb_data;

    logic        out_en_a, out_en_b, valid_a, valid_b;
    logic [23:0] out_rgb_a, out_rgb_b;
    logic [9:0]  gain_r_a, gain_b_a, gain_r_b, gain_b_b;

    int vectors     = 0;
    int miscompares = 0;
    int vcnt_b      = 0;
    int encnt_b     = 0;

    isp_awb #(.BITS(8), .WIDTH(4), .HEIGHT(2), .SUM_W(32)) dut_a (
        .pclk(pclk), .rst_n(rst_n), .in_awb_enable(awb_enable),
        .in_rgb_data_en(rgb_en), .in_rgb_data(rgb_data),
        .out_awb_rgb_en(out_en_a), .out_awb_rgb(out_rgb_a),
        .out_gain_r(gain_r_a), .out_gain_b(gain_b_a), .out_gain_valid(valid_a)
    );

    isp_awb #(.BITS(8), .WIDTH(8), .HEIGHT(4), .SUM_W(32)) dut_b (
        .pclk(pclk), .rst_n(rst_n), .in_awb_enable(awb_enable),
        .in_rgb_data_en(rgb_en), .in_rgb_data(rgb_data),
        .out_awb_rgb_en(out_en_b), .out_awb_rgb(out_rgb_b),
        .out_gain_r(gain_r_b), .out_gain_b(gain_b_b), .out_gain_valid(valid_b)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Count gain pulses and output-valid cycles of the 32-pixel instance since reset.
    always @(posedge pclk) begin
        if (!rst_n) begin
            vcnt_b  <= 0;
            encnt_b <= 0;
        end else begin
            if (valid_b === 1'b1) vcnt_b <= vcnt_b + 1;
            if (out_en_b === 1'b1) encnt_b <= encnt_b + 1;
        end
    end

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        rgb_en   = 1'b1;
        rgb_data = {r, g, b};
        step();
    endtask

    task automatic idle();
        rgb_en   = 1'b0;
        rgb_data = 24'd0;
        step();
    endtask

    task automatic wait_gain(input string tag, input int exp_lat);
        int pulses = 0;
        int lat    = -1;
        rgb_en   = 1'b0;
        rgb_data = 24'd0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (valid_a === 1'b1) begin
                pulses++;
                lat = k;
            end
        end
        chk({tag, "_pulses"}, pulses, 32'd1);
        chk({tag, "_latency"}, lat, exp_lat);
    endtask

    initial begin
        rst_n      = 1'b0;
        awb_enable = 1'b0;
        rgb_en     = 1'b0;
        rgb_data   = 24'd0;
        repeat (3) step();
        chk("rst_en", out_en_a, 32'd0);
        chk("rst_rgb", out_rgb_a, 32'd0);
        chk("rst_gain_r", gain_r_a, 32'd256);
        chk("rst_gain_b", gain_b_a, 32'd256);
        chk("rst_valid", valid_a, 32'd0);
        rst_n = 1'b1;
        repeat (2) step();

        // Bypass: pixel comes out unchanged three edges after capture
        pix(8'd200, 8'd100, 8'd50);
        pix(8'd10, 8'd200, 8'd10);
        chk("bypass_en_early", out_en_a, 32'd0);
        pix(8'd10, 8'd200, 8'd10);
        chk("bypass_rgb", out_rgb_a, {8'd200, 8'd100, 8'd50});
        chk("bypass_en", out_en_a, 32'd1);

        // Mid-stream reset discards the three partial pixels
        rst_n = 1'b0;
        #1;
        chk("midrst_en", out_en_a, 32'd0);
        chk("midrst_rgb", out_rgb_a, 32'd0);
        chk("midrst_valid", valid_a, 32'd0);
        rgb_en   = 1'b0;
        rgb_data = 24'd0;
        step();
        rst_n = 1'b1;
        step();

        // Frame 1: uniform {64,128,32} -> R gain 2.0, B gain saturates
        awb_enable = 1'b1;
        repeat (8) pix(8'd64, 8'd128, 8'd32);
        wait_gain("f1", 13);
        chk("f1_gain_r", gain_r_a, 32'd512);
        chk("f1_gain_b", gain_b_a, 32'd1023);

        // Frame 2 begins with the apply checks
        pix(8'd64, 8'd128, 8'd32);
        idle();
        idle();
        chk("apply_rgb", out_rgb_a, {8'd128, 8'd128, 8'd127});
        idle();
        chk("idle_rgb_zero", out_rgb_a, 32'd0);
        chk("idle_en_zero", out_en_a, 32'd0);
        pix(8'd200, 8'd50, 8'd255);
        idle();
        idle();
        chk("clip_rgb", out_rgb_a, {8'd255, 8'd50, 8'd255});
        awb_enable = 1'b0;
        pix(8'd200, 8'd100, 8'd50);
        idle();
        idle();
        chk("bypass2_rgb", out_rgb_a, {8'd200, 8'd100, 8'd50});
        awb_enable = 1'b1;
        // Sums r=464 g=278 b=337: gains floor(278*256/464)=153, floor(278*256/337)=211
        repeat (5) pix(8'd0, 8'd0, 8'd0);
        wait_gain("f2", 23);
        chk("f2_gain_r", gain_r_a, 32'd153);
        chk("f2_gain_b", gain_b_a, 32'd211);

        // Zero R divisor
        repeat (8) pix(8'd0, 8'd100, 8'd100);
        wait_gain("zdiv", 13);
        chk("zdiv_gain_r", gain_r_a, 32'd1023);
        chk("zdiv_gain_b", gain_b_a, 32'd256);

        // Reset restores unity gains, then back-to-back 32-pixel frames on dut_b
        rst_n = 1'b0;
        #1;
        chk("rst2_gain_r", gain_r_a, 32'd256);
        step();
        rst_n = 1'b1;
        for (int p = 1; p <= 96; p++) begin
            if (p <= 32) pix(8'd64, 8'd128, 8'd32);
            else         pix(8'd100, 8'd100, 8'd200);
            if (p == 67) chk("b2b_old_gain_rgb", out_rgb_b, {8'd200, 8'd100, 8'd255});
            if (p == 80) chk("b2b_mid_gain_r", gain_r_b, 32'd512);
            if (p == 87) chk("b2b_update_pulse", valid_b, 32'd1);
            if (p == 90) chk("b2b_new_gain_b", gain_b_b, 32'd128);
            if (p == 96) chk("b2b_new_gain_rgb", out_rgb_b, {8'd100, 8'd100, 8'd100});
        end
        repeat (4) idle();
        chk("b2b_pulses", vcnt_b, 32'd2);
        chk("b2b_en_cycles", encnt_b, 32'd96);
        chk("b2b_gain_r", gain_r_b, 32'd256);
        chk("b2b_gain_b", gain_b_b, 32'd128);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
